// File: rtl/uart_rx.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// uart_rx
//   8N1 UART receiver with a first-word-fall-through receive FIFO.
//   The pin passes through a two-flop synchroniser. A single baud counter times
//   the half-bit delay to the middle of the start bit, then full bit periods
//   for the eight data bits and the stop bit. Good bytes go into the FIFO.
//   A low stop bit is reported as a framing error. A good byte that finds the
//   FIFO full is reported as an overrun.
//
// Parameters
//   CLK_FREQ    core clock frequency in Hz
//   BAUD        line rate in bit/s (bit period = CLK_FREQ/BAUD, truncated)
//   FIFO_DEPTH  receive FIFO entries, power of 2, >= 2
//
// Ports
//   clk        core clock, all logic on the rising edge
//   rst_n      synchronous reset, active-low
//   rx         asynchronous serial input, idle-high
//   rd         pop the FIFO head (ignored while empty)
//   rd_data    FIFO head byte, 8'h00 while empty
//   empty      FIFO holds no bytes
//   full       FIFO holds FIFO_DEPTH bytes
//   count      number of bytes held
//   busy       receiver is not idle
//   frame_err  one-cycle pulse: stop bit sampled low
//   overrun    one-cycle pulse: good byte dropped because the FIFO was full
// -----------------------------------------------------------------------------
module uart_rx #(
  parameter int CLK_FREQ   = 10_000_000,
  parameter int BAUD       = 9600,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              rx,
  input  logic                              rd,
  output logic [7:0]                        rd_data,
  output logic                              empty,
  output logic                              full,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   count,
  output logic                              busy,
  output logic                              frame_err,
  output logic                              overrun
);

  localparam int DIV   = CLK_FREQ / BAUD;
  localparam int HALF  = DIV / 2;
  localparam int CNT_W = $clog2(DIV + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CW    = $clog2(FIFO_DEPTH + 1);

  localparam logic [CNT_W-1:0] LOAD_FULL = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] LOAD_HALF = CNT_W'(HALF - 1);
  localparam logic [CW-1:0]    CNT_FULL  = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } state_t;

  // synchroniser
  logic sync1_r;
  logic rxs_r;

  // receiver state
  state_t           state_r,  state_s;
  logic [CNT_W-1:0] baud_cnt_r, baud_cnt_s;
  logic [2:0]       idx_r,    idx_s;
  logic [7:0]       shift_r,  shift_s;
  logic             tick_s;
  logic             push_s;
  logic             frame_err_s;
  logic             overrun_s;
  logic             frame_err_r;
  logic             overrun_r;

  // FIFO storage
  logic [7:0]       mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             pop_s;
  logic             empty_s;
  logic             full_s;

  // Two-flop synchroniser on the asynchronous pin; resets to the idle level.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_r <= 1'b1;
      rxs_r   <= 1'b1;
    end else begin
      sync1_r <= rx;
      rxs_r   <= sync1_r;
    end
  end

  assign tick_s  = (baud_cnt_r == {CNT_W{1'b0}});
  assign empty_s = (count_r == {CW{1'b0}});
  assign full_s  = (count_r == CNT_FULL);
  // A pop is only honoured when there is something to pop.
  assign pop_s   = rd & ~empty_s;

  // Receiver next-state, counter, shift register and event decode.
  always_comb begin
    state_s     = state_r;
    idx_s       = idx_r;
    shift_s     = shift_r;
    push_s      = 1'b0;
    frame_err_s = 1'b0;
    overrun_s   = 1'b0;
    // While timing a bit the counter runs down and reloads a full period.
    if (tick_s) begin
      baud_cnt_s = LOAD_FULL;
    end else begin
      baud_cnt_s = baud_cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
    end

    case (state_r)
      ST_IDLE: begin
        if (!rxs_r) begin
          state_s    = ST_START;
          baud_cnt_s = LOAD_HALF;
        end else begin
          baud_cnt_s = baud_cnt_r;
        end
      end
      ST_START: begin
        if (tick_s) begin
          if (!rxs_r) begin
            state_s = ST_DATA;
            idx_s   = 3'd0;
          end else begin
            // line went back high before mid start bit: glitch, no flags
            state_s = ST_IDLE;
          end
        end else begin
          state_s = ST_START;
        end
      end
      ST_DATA: begin
        if (tick_s) begin
          shift_s[idx_r] = rxs_r;
          if (idx_r == 3'd7) begin
            state_s = ST_STOP;
          end else begin
            idx_s = idx_r + 3'd1;
          end
        end else begin
          state_s = ST_DATA;
        end
      end
      ST_STOP: begin
        if (tick_s) begin
          if (rxs_r) begin
            state_s = ST_IDLE;
            // a simultaneous pop frees the slot even when full
            if (!full_s || rd) begin
              push_s = 1'b1;
            end else begin
              overrun_s = 1'b1;
            end
          end else begin
            state_s     = ST_BREAK;
            frame_err_s = 1'b1;
          end
        end else begin
          state_s = ST_STOP;
        end
      end
      ST_BREAK: begin
        baud_cnt_s = baud_cnt_r;
        // no start detection until the line has returned high
        if (rxs_r) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_BREAK;
        end
      end
      default: begin
        state_s    = ST_IDLE;
        baud_cnt_s = {CNT_W{1'b0}};
      end
    endcase
  end

  // Receiver state registers and registered status pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      baud_cnt_r  <= {CNT_W{1'b0}};
      idx_r       <= 3'd0;
      shift_r     <= 8'h00;
      frame_err_r <= 1'b0;
      overrun_r   <= 1'b0;
    end else begin
      state_r     <= state_s;
      baud_cnt_r  <= baud_cnt_s;
      idx_r       <= idx_s;
      shift_r     <= shift_s;
      frame_err_r <= frame_err_s;
      overrun_r   <= overrun_s;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at FIFO_DEPTH.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
        2'b01:   count_r <= count_r - {{(CW-1){1'b0}}, 1'b1};
        default: count_r <= count_r;
      endcase
    end
  end

  // FIFO storage. Not reset: a slot is never visible before it is written,
  // because rd_data is forced to zero while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= shift_r;
    end
  end

  // First-word-fall-through head output.
  always_comb begin
    if (empty_s) begin
      rd_data = 8'h00;
    end else begin
      rd_data = mem_r[rd_ptr_r];
    end
  end

  assign empty     = empty_s;
  assign full      = full_s;
  assign count     = count_r;
  assign busy      = (state_r != ST_IDLE);
  assign frame_err = frame_err_r;
  assign overrun   = overrun_r;

endmodule

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
// Self-checking bench for uart_rx: a queue-based model of the FIFO and of the
// frame outcomes is compared with the DUT on every cycle; directed tests add
// literal expectations.
module tb_uart_rx;

  localparam int CLK_FREQ = 1_000_000;
  localparam int BAUD     = 9600;
  localparam int DEPTH    = 8;
  localparam int DIV      = CLK_FREQ / BAUD;   // 104
  localparam int HALF     = DIV / 2;           // 52
  localparam int LAT      = 3;                 // 2 sync flops + detect edge

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx    = 1'b1;
  logic       rd    = 1'b0;
  logic [7:0] rd_data;
  logic       empty;
  logic       full;
  logic [3:0] count;
  logic       busy;
  logic       frame_err;
  logic       overrun;

  uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .rd(rd), .rd_data(rd_data),
    .empty(empty), .full(full), .count(count), .busy(busy),
    .frame_err(frame_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  typedef struct {
    int         cyc;
    logic [7:0] b;
    bit         ok;
  } ev_t;

  ev_t        evq[$];
  logic [7:0] q[$];
  int         cyc = 0;
  bit         exp_fe = 1'b0;
  bit         exp_ov = 1'b0;
  bit         model_live = 1'b0;
  int         fe_cnt = 0;
  int         ov_cnt = 0;
  int         stop_cyc = 0;

  // At every edge: reset clears everything; otherwise pop, then the frame
  // outcome whose stop bit is sampled on this edge.
  initial begin
    ev_t e;
    forever begin
      @(posedge clk);
      cyc++;
      exp_fe = 1'b0;
      exp_ov = 1'b0;
      if (!rst_n) begin
        q.delete();
        evq.delete();
        model_live = 1'b1;
      end else begin
        if (rd && q.size() > 0) void'(q.pop_front());
        if (evq.size() > 0 && evq[0].cyc == cyc) begin
          e = evq.pop_front();
          if (!e.ok) exp_fe = 1'b1;
          else if (q.size() < DEPTH) q.push_back(e.b);
          else exp_ov = 1'b1;
        end
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (model_live) begin
        chk("empty", 32'(empty), 32'(q.size() == 0));
        chk("full", 32'(full), 32'(q.size() == DEPTH));
        chk("count", 32'(count), q.size());
        chk("rd_data", 32'(rd_data), (q.size() > 0) ? 32'(q[0]) : 32'h0);
        chk("frame_err", 32'(frame_err), 32'(exp_fe));
        chk("overrun", 32'(overrun), 32'(exp_ov));
        if (frame_err === 1'b1) fe_cnt++;
        if (overrun === 1'b1) ov_cnt++;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive one 10-bit frame; registers its expected outcome with the model.
  task automatic send_frame(input logic [7:0] b, input bit stop_bit);
    logic [9:0] bits;
    bits = {stop_bit, b, 1'b0};
    @(posedge clk);
    #1;
    stop_cyc = cyc + LAT + HALF + 9 * DIV;
    evq.push_back('{stop_cyc, b, stop_bit});
    for (int i = 0; i < 10; i++) begin
      rx = bits[i];
      repeat (DIV) @(posedge clk);
      #1;
    end
  endtask

  task automatic pop_byte(input logic [7:0] exp, input string nm);
    chk(nm, 32'(rd_data), 32'(exp));
    rd = 1'b1;
    @(posedge clk);
    #1;
    rd = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_empty"}, 32'(empty), 32'h1);
    chk({nm, "_full"}, 32'(full), 32'h0);
    chk({nm, "_count"}, 32'(count), 32'h0);
    chk({nm, "_rd_data"}, 32'(rd_data), 32'h0);
    chk({nm, "_busy"}, 32'(busy), 32'h0);
    chk({nm, "_frame_err"}, 32'(frame_err), 32'h0);
    chk({nm, "_overrun"}, 32'(overrun), 32'h0);
  endtask

  // Watchdog: the whole run is about 20k cycles.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish by %0t", $time);
    $fatal(1, "watchdog");
  end

  logic [7:0] exp_tail [8];

  initial begin
    // reset
    rst_n = 1'b0;
    idle(3);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    idle(5);

    // 0xA5 with exact push timing
    fork
      send_frame(8'hA5, 1'b1);
      begin
        @(posedge clk);
        #2;
        while (cyc < stop_cyc - 1) @(posedge clk);
        #1;
        chk("a5_pre_empty", 32'(empty), 32'h1);
        chk("a5_pre_busy", 32'(busy), 32'h1);
        @(posedge clk);
        #1;
        chk("a5_empty", 32'(empty), 32'h0);
        chk("a5_count", 32'(count), 32'h1);
        chk("a5_rd_data", 32'(rd_data), 32'hA5);
        chk("a5_busy", 32'(busy), 32'h0);
      end
    join
    pop_byte(8'hA5, "a5_pop");
    chk("a5_after_empty", 32'(empty), 32'h1);
    chk("a5_after_rd_data", 32'(rd_data), 32'h0);

    // false start: low for less than half a bit
    rx = 1'b0;
    idle(10);
    chk("glitch_busy", 32'(busy), 32'h1);
    idle(30);
    rx = 1'b1;
    idle(DIV);
    chk("glitch_busy_end", 32'(busy), 32'h0);
    chk("glitch_count", 32'(count), 32'h0);
    chk("glitch_fe", 32'(fe_cnt), 32'h0);

    // framing error then break then a good byte
    send_frame(8'h3C, 1'b0);
    idle(3 * DIV);
    chk("break_busy", 32'(busy), 32'h1);
    rx = 1'b1;
    idle(DIV);
    chk("break_idle", 32'(busy), 32'h0);
    send_frame(8'h55, 1'b1);
    chk("fe_pulses", 32'(fe_cnt), 32'h1);
    chk("fe_count", 32'(count), 32'h1);
    pop_byte(8'h55, "fe_byte55");

    // nine back-to-back bytes: last one overruns
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b1);
    chk("ov_full", 32'(full), 32'h1);
    chk("ov_count", 32'(count), 32'h8);
    chk("ov_pulses", 32'(ov_cnt), 32'h1);
    chk("ov_head", 32'(rd_data), 32'h01);

    // tenth byte with a pop exactly at the stop sample
    fork
      send_frame(8'h0A, 1'b1);
      begin
        @(posedge clk);
        #2;
        while (cyc < stop_cyc - 1) @(posedge clk);
        #1;
        rd = 1'b1;
        @(posedge clk);
        #1;
        rd = 1'b0;
        chk("rdpush_count", 32'(count), 32'h8);
        chk("rdpush_full", 32'(full), 32'h1);
      end
    join
    chk("rdpush_no_ov", 32'(ov_cnt), 32'h1);
    exp_tail = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h0A};
    for (int i = 0; i < 8; i++) pop_byte(exp_tail[i], "drain");
    chk("drain_empty", 32'(empty), 32'h1);

    // reset during data bit 4 of an aborted frame
    rx = 1'b0;
    idle(5 * DIV);
    rx = 1'b1;
    idle(HALF);
    chk("abort_busy", 32'(busy), 32'h1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk_reset_outputs("midreset");
    idle(12 * DIV);
    chk("abort_count", 32'(count), 32'h0);
    chk("abort_busy_end", 32'(busy), 32'h0);
    send_frame(8'hC3, 1'b1);
    chk("c3_count", 32'(count), 32'h1);
    pop_byte(8'hC3, "c3_byte");
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
